// File: rtl/hrm_fetch.sv
// HRM CPU instruction fetch stage: reads opcode/operand bytes, drives the IR load bus,
// presents a ready instruction to control. Optional stall counter: HRM_FETCH_STALLCNT_EN.
module hrm_fetch #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            pm_rd,
    output logic [PC_W-1:0] pm_addr,
    input  logic [7:0]      pm_rdata,
    input  logic            pm_valid,
    output logic [7:0]      nIR,
    output logic            wIR,
    output logic [7:0]      operand,
    output logic            instr_valid,
    output logic            halted,
    input  logic            ctl_next,
    input  logic            ctl_jump,
    input  logic [PC_W-1:0] ctl_target,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        READY     = 2'd2,
        HALTED    = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      nir_q, nir_d;
    logic [7:0]      operand_q, operand_d;
    logic            wir_q, wir_d;
    logic            ivld_q;
    logic            halted_q;
    logic            accept;

    // Gating with rst_n keeps the request low for the whole reset assertion.
    assign pm_rd       = rst_n && ((state_q == FETCH_OP) || (state_q == FETCH_ARG));
    assign pm_addr     = pc_q;
    assign accept      = pm_rd && pm_valid;
    assign nIR         = nir_q;
    assign wIR         = wir_q;
    assign operand     = operand_q;
    assign instr_valid = ivld_q;
    assign halted      = halted_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        nir_d     = nir_q;
        operand_d = operand_q;
        wir_d     = 1'b0;
        case (state_q)
            FETCH_OP: begin
                if (accept) begin
                    nir_d = pm_rdata;
                    wir_d = 1'b1;
                    pc_d  = pc_q + PC_W'(1);
                    case (pm_rdata[7:4])
                        4'h0, 4'h1: state_d = READY;
                        4'hF:       state_d = HALTED;
                        default:    state_d = FETCH_ARG;
                    endcase
                end
            end
            FETCH_ARG: begin
                if (accept) begin
                    operand_d = pm_rdata;
                    pc_d      = pc_q + PC_W'(1);
                    state_d   = READY;
                end
            end
            READY: begin
                // PC already points past the instruction, so ctl_next needs no PC update.
                if (ctl_jump) begin
                    pc_d    = ctl_target;
                    state_d = FETCH_OP;
                end else if (ctl_next) begin
                    state_d = FETCH_OP;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH_OP;
            pc_q      <= RST_PC;
            nir_q     <= 8'h00;
            operand_q <= 8'h00;
            wir_q     <= 1'b0;
            ivld_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            nir_q     <= nir_d;
            operand_q <= operand_d;
            wir_q     <= wir_d;
            ivld_q    <= (state_d == READY);
            halted_q  <= (state_d == HALTED);
        end
    end

`ifdef HRM_FETCH_STALLCNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
        end else if (pm_rd && !pm_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hrm_fetch.sv
// Directed bench for hrm_fetch: per-cycle vector table plus reset corner sequences.
module tb_hrm_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pm_rd;
    logic [7:0]  pm_addr;
    logic [7:0]  pm_rdata;
    logic        pm_valid;
    logic [7:0]  nIR;
    logic        wIR;
    logic [7:0]  operand;
    logic        instr_valid;
    logic        halted;
    logic        ctl_next;
    logic        ctl_jump;
    logic [7:0]  ctl_target;
    logic [15:0] stall_cnt;

`ifdef HRM_FETCH_STALLCNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    hrm_fetch #(.PC_W(8), .RESET_PC(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .pm_rd(pm_rd), .pm_addr(pm_addr), .pm_rdata(pm_rdata), .pm_valid(pm_valid),
        .nIR(nIR), .wIR(wIR), .operand(operand),
        .instr_valid(instr_valid), .halted(halted),
        .ctl_next(ctl_next), .ctl_jump(ctl_jump), .ctl_target(ctl_target),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] rdata;
        logic       nxt;
        logic       jmp;
        logic [7:0] tgt;
        logic       e_rd;
        logic [7:0] e_addr;
        logic [7:0] e_nir;
        logic       e_wir;
        logic [7:0] e_op;
        logic       e_iv;
        logic       e_h;
        int         e_stall;
    } vec_t;

    vec_t vecs[23];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [step %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] rd, input logic n, input logic j,
                                input logic [7:0] t, input logic erd, input logic [7:0] ea,
                                input logic [7:0] en, input logic ew, input logic [7:0] eo,
                                input logic ei, input logic eh, input int es);
        vec_t r;
        r.valid = v;  r.rdata = rd; r.nxt = n;  r.jmp = j;  r.tgt = t;
        r.e_rd = erd; r.e_addr = ea; r.e_nir = en; r.e_wir = ew; r.e_op = eo;
        r.e_iv = ei;  r.e_h = eh;    r.e_stall = es;
        return r;
    endfunction

    function automatic int stall_exp(input int n);
        return STALL_ON ? n : 0;
    endfunction

    initial begin
        //            vld rdata nxt jmp tgt    rd addr   nIR  wIR op    iv h  stall
        vecs[0]  = mk(1, 8'h00, 0, 0, 8'h00,  1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 8'h00, 0, 0, 8'h00,  0, 8'h01, 8'h00, 1, 8'h00, 1, 0, 0);
        vecs[2]  = mk(0, 8'h00, 1, 0, 8'h00,  0, 8'h01, 8'h00, 0, 8'h00, 1, 0, 0);
        vecs[3]  = mk(0, 8'h00, 0, 0, 8'h00,  1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 0);
        vecs[4]  = mk(0, 8'h00, 0, 0, 8'h00,  1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 1);
        vecs[5]  = mk(0, 8'h00, 0, 0, 8'h00,  1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 2);
        vecs[6]  = mk(1, 8'h30, 0, 0, 8'h00,  1, 8'h01, 8'h00, 0, 8'h00, 0, 0, 3);
        vecs[7]  = mk(0, 8'h00, 0, 0, 8'h00,  1, 8'h02, 8'h30, 1, 8'h00, 0, 0, 3);
        vecs[8]  = mk(0, 8'h00, 0, 0, 8'h00,  1, 8'h02, 8'h30, 0, 8'h00, 0, 0, 4);
        vecs[9]  = mk(0, 8'h00, 0, 0, 8'h00,  1, 8'h02, 8'h30, 0, 8'h00, 0, 0, 5);
        vecs[10] = mk(1, 8'h05, 0, 0, 8'h00,  1, 8'h02, 8'h30, 0, 8'h00, 0, 0, 6);
        vecs[11] = mk(1, 8'hEE, 0, 0, 8'h00,  0, 8'h03, 8'h30, 0, 8'h05, 1, 0, 6);
        vecs[12] = mk(0, 8'h00, 1, 1, 8'h40,  0, 8'h03, 8'h30, 0, 8'h05, 1, 0, 6);
        vecs[13] = mk(1, 8'h10, 0, 0, 8'h00,  1, 8'h40, 8'h30, 0, 8'h05, 0, 0, 6);
        vecs[14] = mk(0, 8'h00, 0, 1, 8'hFF,  0, 8'h41, 8'h10, 1, 8'h05, 1, 0, 6);
        vecs[15] = mk(1, 8'h80, 0, 0, 8'h00,  1, 8'hFF, 8'h10, 0, 8'h05, 0, 0, 6);
        vecs[16] = mk(1, 8'h12, 1, 0, 8'h00,  1, 8'h00, 8'h80, 1, 8'h05, 0, 0, 6);
        vecs[17] = mk(0, 8'h00, 0, 0, 8'h00,  0, 8'h01, 8'h80, 0, 8'h12, 1, 0, 6);
        vecs[18] = mk(0, 8'h00, 1, 0, 8'h00,  0, 8'h01, 8'h80, 0, 8'h12, 1, 0, 6);
        vecs[19] = mk(1, 8'hF0, 0, 0, 8'h00,  1, 8'h01, 8'h80, 0, 8'h12, 0, 0, 6);
        vecs[20] = mk(1, 8'h00, 1, 0, 8'h00,  0, 8'h02, 8'hF0, 1, 8'h12, 0, 1, 6);
        vecs[21] = mk(1, 8'h00, 0, 1, 8'h10,  0, 8'h02, 8'hF0, 0, 8'h12, 0, 1, 6);
        vecs[22] = mk(0, 8'h00, 0, 0, 8'h00,  0, 8'h02, 8'hF0, 0, 8'h12, 0, 1, 6);

        rst_n = 1'b0; pm_valid = 1'b0; pm_rdata = 8'h00;
        ctl_next = 1'b0; ctl_jump = 1'b0; ctl_target = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_pm_rd", -1, 32'(pm_rd), 32'd0);
        chk("rst_addr", -1, 32'(pm_addr), 32'h00);
        chk("rst_nIR", -1, 32'(nIR), 32'h00);
        chk("rst_wIR", -1, 32'(wIR), 32'd0);
        chk("rst_operand", -1, 32'(operand), 32'h00);
        chk("rst_ivalid", -1, 32'(instr_valid), 32'd0);
        chk("rst_halted", -1, 32'(halted), 32'd0);
        chk("rst_stall", -1, 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            pm_valid = vecs[i].valid; pm_rdata = vecs[i].rdata;
            ctl_next = vecs[i].nxt;   ctl_jump = vecs[i].jmp; ctl_target = vecs[i].tgt;
            #1;
            chk("pm_rd", i, 32'(pm_rd), 32'(vecs[i].e_rd));
            chk("pm_addr", i, 32'(pm_addr), 32'(vecs[i].e_addr));
            chk("nIR", i, 32'(nIR), 32'(vecs[i].e_nir));
            chk("wIR", i, 32'(wIR), 32'(vecs[i].e_wir));
            chk("operand", i, 32'(operand), 32'(vecs[i].e_op));
            chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_iv));
            chk("halted", i, 32'(halted), 32'(vecs[i].e_h));
            chk("stall_cnt", i, 32'(stall_cnt), 32'(stall_exp(vecs[i].e_stall)));
            @(negedge clk);
        end
        pm_valid = 1'b0; ctl_next = 1'b0; ctl_jump = 1'b0;

        // Reset out of HALTED, asynchronously mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("halt_rst_pm_rd", 100, 32'(pm_rd), 32'd0);
        chk("halt_rst_addr", 100, 32'(pm_addr), 32'h00);
        chk("halt_rst_halted", 100, 32'(halted), 32'd0);
        chk("halt_rst_nIR", 100, 32'(nIR), 32'h00);
        chk("halt_rst_operand", 100, 32'(operand), 32'h00);
        chk("halt_rst_stall", 100, 32'(stall_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1; pm_valid = 1'b1; pm_rdata = 8'h20;
        #1;
        chk("resume_pm_rd", 101, 32'(pm_rd), 32'd1);
        chk("resume_addr", 101, 32'(pm_addr), 32'h00);
        @(negedge clk);
        pm_valid = 1'b0;
        #1;
        chk("arg_wait_addr", 102, 32'(pm_addr), 32'h01);
        chk("arg_wait_nIR", 102, 32'(nIR), 32'h20);
        chk("arg_wait_wIR", 102, 32'(wIR), 32'd1);
        @(negedge clk);

        // Reset while awaiting the operand byte; a late pm_valid must be ignored.
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_pm_rd", 103, 32'(pm_rd), 32'd0);
        chk("midrst_addr", 103, 32'(pm_addr), 32'h00);
        chk("midrst_nIR", 103, 32'(nIR), 32'h00);
        chk("midrst_stall", 103, 32'(stall_cnt), 32'd0);
        pm_valid = 1'b1; pm_rdata = 8'h55;
        @(negedge clk);
        #1;
        chk("late_valid_nIR", 104, 32'(nIR), 32'h00);
        chk("late_valid_operand", 104, 32'(operand), 32'h00);
        chk("late_valid_addr", 104, 32'(pm_addr), 32'h00);
        chk("late_valid_wIR", 104, 32'(wIR), 32'd0);
        rst_n = 1'b1; pm_valid = 1'b0;
        #1;
        chk("post_rst_pm_rd", 105, 32'(pm_rd), 32'd1);
        chk("post_rst_addr", 105, 32'(pm_addr), 32'h00);
        @(negedge clk);
        #1;
        chk("post_rst_stall", 106, 32'(stall_cnt), 32'(stall_exp(1)));
        chk("post_rst_hold_addr", 106, 32'(pm_addr), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
